// File: rtl/alu_pkg.sv
// Shared Level 02 ALU definitions: serial-adder FSM state encoding and
// add/subtract opcode values.
package alu_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full-adder slice; the only arithmetic in the bit-serial adder.
module full_adder_1bit (
   input  logic in0,
   input  logic in1,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = in0 ^ in1 ^ cin;
   assign cout = (in0 & in1) | (in0 & cin) | (in1 & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one full-adder slice, start/busy/done handshake.
// Define SERIAL_ADDER_FLAGS_EN to add registered zero and signed-overflow outputs.
module serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADDER_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] res_next;

   full_adder_1bit u_fa (
      .in0  (a_sr[0]),
      .in1  (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Result register as it stands once the current slice bit lands in the MSB.
   always_comb begin
      res_next = {fa_sum, res_sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
         zero   <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtract is A + ~B + 1: invert B here, seed carry with the +1.
                  a_sr   <= a;
                  b_sr   <= b ^ {WIDTH{op_sub == OP_SUB}};
                  carry  <= (op_sub == OP_SUB);
                  res_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               res_sr <= res_next;
               carry  <= fa_cout;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  result <= res_next;
                  cout   <= fa_cout;
`ifdef SERIAL_ADDER_FLAGS_EN
                  zero   <= (res_next == '0);
                  // carry still holds the carry into the MSB on the last bit.
                  ovf    <= carry ^ fa_cout;
`endif
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8): vector table plus
// handshake, back-to-back and mid-operation reset sequences.
module tb_serial_adder;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
`ifdef SERIAL_ADDER_FLAGS_EN
   logic         zero;
   logic         ovf;
`endif

   int cmps = 0;
   int errs = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
`ifdef SERIAL_ADDER_FLAGS_EN
      ,
      .zero   (zero),
      .ovf    (ovf)
`endif
   );

   typedef struct {
      logic         op;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] exp_res;
      logic         exp_cout;
      logic         exp_zero;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Launch one op and wait for done; lat counts posedges after the accepting edge.
   task automatic run_op(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int lat, output logic busy_ok);
      @(negedge clk);
      start = 1'b1; op_sub = op; a = va; b = vb;
      @(posedge clk); #1;
      busy_ok = busy;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!done && !busy) busy_ok = 1'b0;
      end
   endtask

   initial begin
      int   lat;
      logic bok;

      vecs[0] = '{OP_ADD, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat, bok);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
         chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
         chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
         chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
`ifdef SERIAL_ADDER_FLAGS_EN
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      end

      // start held high with operands changing while busy: only the first op counts.
      @(negedge clk);
      start = 1'b1; op_sub = OP_ADD; a = 8'h12; b = 8'h34;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         a = a + 8'h11; b = b ^ 8'hFF; op_sub = ~op_sub;
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < 20);
      @(negedge clk);
      start = 1'b0;
      chk("hold_latency", 32'(lat), 32'd8);
      chk("hold_result", 32'(result), 32'h46);
      chk("hold_cout", 32'(cout), 32'd0);
      @(posedge clk); #1;
      chk("hold_no_reaccept", 32'(busy), 32'd0);

      // Back-to-back: start during the done cycle is accepted with no gap.
      run_op(OP_ADD, 8'h01, 8'h01, lat, bok);
      chk("b2b_first_result", 32'(result), 32'h02);
      start = 1'b1; op_sub = OP_ADD; a = 8'h20; b = 8'h03;
      @(posedge clk); #1;
      chk("b2b_busy_no_gap", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      bok = 1'b1;
      while (!done && lat < 20) begin
         if (result !== 8'h02) bok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_result_held", 32'(bok), 32'd1);
      chk("b2b_latency", 32'(lat), 32'd8);
      chk("b2b_second_result", 32'(result), 32'h23);

      // Reset during bit 4 aborts with no done pulse.
      @(negedge clk);
      start = 1'b1; op_sub = OP_ADD; a = 8'h5A; b = 8'h33;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_result", 32'(result), 32'd0);
      chk("rst_mid_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bok = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) bok = 1'b1;
      end
      chk("rst_mid_no_done", 32'(bok), 32'd0);
      run_op(OP_ADD, 8'h01, 8'h02, lat, bok);
      chk("post_rst_latency", 32'(lat), 32'd8);
      chk("post_rst_result", 32'(result), 32'h03);
      chk("post_rst_cout", 32'(cout), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
